// File: rtl/mycpu_sb_pkg.sv
// Shared scoreboard constants and GPR index type, also used by decode.
package mycpu_sb_pkg;

    localparam int unsigned NUM_GPR = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned GPR_W   = 5;

    typedef logic [GPR_W-1:0] gpr_idx_t;

endpackage

// File: rtl/sb_entry.sv
// One register's scoreboard state: saturating outstanding-write count and late-result flag.
module sb_entry
    import mycpu_sb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    input  logic             set_late,
    input  logic             clr_late,
    output logic [CNT_W-1:0] cnt,
    output logic             late,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Same-cycle inc+dec cancel; flush suppresses events so it never reports an error.
    assign ovf = ~flush & inc & ~dec & (cnt == CNT_MAX);
    assign unf = ~flush & dec & ~inc & (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt  <= '0;
            late <= 1'b0;
        end else begin
            if (inc && !dec && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end else if (dec && !inc && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A new load entering ES outranks the old one leaving it.
            if (set_late) begin
                late <= 1'b1;
            end else if (clr_late) begin
                late <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard: tracks outstanding GPR writes and stalls decode on late (load) results.
module id_scoreboard
    import mycpu_sb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     ds_valid,
    input  gpr_idx_t ds_rs,
    input  gpr_idx_t ds_rt,
    input  logic     ds_use_rs,
    input  logic     ds_use_rt,
    input  logic     issue,
    input  logic     issue_we,
    input  gpr_idx_t issue_dest,
    input  logic     issue_late,
    input  logic     es_late_done,
    input  gpr_idx_t es_late_dest,
    input  logic     ws_retire,
    input  gpr_idx_t ws_dest,
    output logic     sb_stall,
    output logic     pending_any,
    output logic     sb_err
);

    logic [NUM_GPR-1:1] late_v;
    logic [NUM_GPR-1:1] nz;
    logic [NUM_GPR-1:1] ovf;
    logic [NUM_GPR-1:1] unf;
    logic [NUM_GPR-1:0] late_all;

    // One-hot event decode per tracked register; r0 has no entry so its events vanish.
    for (genvar r = 1; r < NUM_GPR; r++) begin : g_ent
        logic             inc;
        logic             dec;
        logic             set_late;
        logic             clr_late;
        logic [CNT_W-1:0] cnt;

        assign inc      = issue & issue_we & (issue_dest == GPR_W'(r));
        assign dec      = ws_retire & (ws_dest == GPR_W'(r));
        assign set_late = inc & issue_late;
        assign clr_late = es_late_done & (es_late_dest == GPR_W'(r));
        assign nz[r]    = (cnt != '0);

        sb_entry u_ent (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .inc      (inc),
            .dec      (dec),
            .set_late (set_late),
            .clr_late (clr_late),
            .cnt      (cnt),
            .late     (late_v[r]),
            .ovf      (ovf[r]),
            .unf      (unf[r])
        );
    end

    // Bit 0 is hard zero, so a source of r0 can never stall.
    assign late_all    = {late_v, 1'b0};
    assign sb_stall    = ds_valid & ((ds_use_rs & late_all[ds_rs]) |
                                     (ds_use_rt & late_all[ds_rt]));
    assign pending_any = |nz;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if ((|ovf) || (|unf)) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed load-use/overflow/flush scenarios plus random traffic against a per-register array model.
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       reset, flush, ds_valid, ds_use_rs, ds_use_rt;
    logic       issue, issue_we, issue_late, es_late_done, ws_retire;
    logic [4:0] ds_rs, ds_rt, issue_dest, es_late_dest, ws_dest;
    logic       sb_stall, pending_any, sb_err;

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt  [32];
    bit m_late [32];
    bit m_err;

    always #5 clk = ~clk;

    id_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ds_valid(ds_valid), .ds_rs(ds_rs), .ds_rt(ds_rt),
        .ds_use_rs(ds_use_rs), .ds_use_rt(ds_use_rt),
        .issue(issue), .issue_we(issue_we), .issue_dest(issue_dest), .issue_late(issue_late),
        .es_late_done(es_late_done), .es_late_dest(es_late_dest),
        .ws_retire(ws_retire), .ws_dest(ws_dest),
        .sb_stall(sb_stall), .pending_any(pending_any), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; ds_valid = 0; ds_use_rs = 0; ds_use_rt = 0; ds_rs = 0; ds_rt = 0;
        issue = 0; issue_we = 0; issue_late = 0; issue_dest = 0;
        es_late_done = 0; es_late_dest = 0; ws_retire = 0; ws_dest = 0;
    endtask

    function automatic bit model_stall();
        bit s_rs, s_rt;
        s_rs = ds_use_rs && ds_rs != 0 && m_late[ds_rs];
        s_rt = ds_use_rt && ds_rt != 0 && m_late[ds_rt];
        return ds_valid && (s_rs || s_rt);
    endfunction

    function automatic bit model_pending();
        for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one clock of the scoreboard rules to the model.
    task automatic model_update();
        bit inc, dec;
        if (reset) begin
            foreach (m_cnt[r]) begin m_cnt[r] = 0; m_late[r] = 0; end
            m_err = 0;
        end else if (flush) begin
            foreach (m_cnt[r]) begin m_cnt[r] = 0; m_late[r] = 0; end
        end else begin
            for (int r = 1; r < 32; r++) begin
                inc = issue && issue_we && issue_dest == 5'(r);
                dec = ws_retire && ws_dest == 5'(r);
                if (inc && !dec) begin
                    if (m_cnt[r] == 3) m_err = 1; else m_cnt[r]++;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
                end
                if (inc && issue_late) m_late[r] = 1;
                else if (es_late_done && es_late_dest == 5'(r)) m_late[r] = 0;
            end
        end
    endtask

    // Called just after a negedge with inputs set: check, clock, update model.
    task automatic tick();
        #1;
        if (!reset) begin
            chk("stall", 32'(sb_stall), 32'(model_stall()));
            chk("pending_any", 32'(pending_any), 32'(model_pending()));
            chk("sb_err", 32'(sb_err), 32'(m_err));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [4:0] d, input logic lt);
        issue = 1; issue_we = 1; issue_dest = d; issue_late = lt;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        foreach (m_cnt[r]) begin m_cnt[r] = 0; m_late[r] = 0; end
        m_err = 0;
        @(negedge clk);
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_stall", 32'(sb_stall), 0);
        chk("rst_pending", 32'(pending_any), 0);
        chk("rst_err", 32'(sb_err), 0);
        for (int i = 0; i < 10; i++) tick();

        // Load-use: one-cycle bubble
        do_issue(8, 1);
        tick();
        idle_inputs();
        ds_valid = 1; ds_rs = 8; ds_use_rs = 1;
        es_late_done = 1; es_late_dest = 8;
        #1 chk("lu_stall_n1", 32'(sb_stall), 1);
        tick();
        es_late_done = 0;
        #1 chk("lu_stall_n2", 32'(sb_stall), 0);
        chk("lu_cnt8", 32'(dut.g_ent[8].u_ent.cnt), 1);
        tick();
        idle_inputs();
        ws_retire = 1; ws_dest = 8;
        tick();
        idle_inputs();
        #1 chk("lu_pending_after_retire", 32'(pending_any), 0);
        tick();

        // ALU dependency never stalls
        do_issue(5, 0);
        tick();
        idle_inputs();
        ds_valid = 1; ds_rs = 5; ds_use_rs = 1; ds_rt = 5; ds_use_rt = 1;
        #1 chk("alu_stall", 32'(sb_stall), 0);
        tick();
        idle_inputs();
        ws_retire = 1; ws_dest = 5;
        tick();

        // Simultaneous issue+retire on r3
        idle_inputs();
        do_issue(3, 0);
        tick();
        ws_retire = 1; ws_dest = 3;
        tick();
        idle_inputs();
        #1 chk("same_cnt3", 32'(dut.g_ent[3].u_ent.cnt), 1);
        chk("same_err", 32'(sb_err), 0);
        ws_retire = 1; ws_dest = 3;
        tick();
        idle_inputs();

        // Overflow on r9
        for (int i = 0; i < 4; i++) begin do_issue(9, 0); tick(); end
        idle_inputs();
        #1 chk("ovf_cnt9", 32'(dut.g_ent[9].u_ent.cnt), 3);
        chk("ovf_err", 32'(sb_err), 1);
        tick();
        reset = 1; tick(); reset = 0;

        // Underflow on r4
        ws_retire = 1; ws_dest = 4;
        tick();
        idle_inputs();
        #1 chk("unf_cnt4", 32'(dut.g_ent[4].u_ent.cnt), 0);
        chk("unf_err", 32'(sb_err), 1);
        tick();
        reset = 1; tick(); reset = 0;

        // Flush overrides a same-cycle issue after a load to r10
        do_issue(10, 1);
        tick();
        idle_inputs();
        ds_valid = 1; ds_rs = 10; ds_use_rs = 1;
        #1 chk("fl_stall_before", 32'(sb_stall), 1);
        flush = 1; do_issue(11, 1);
        tick();
        flush = 0; issue = 0; issue_we = 0; issue_late = 0;
        #1 chk("fl_stall_after", 32'(sb_stall), 0);
        chk("fl_late10", 32'(dut.g_ent[10].u_ent.late), 0);
        chk("fl_pending", 32'(pending_any), 0);
        tick();

        // r0 events are ignored
        idle_inputs();
        do_issue(0, 1);
        tick();
        idle_inputs();
        #1 chk("r0_pending", 32'(pending_any), 0);
        ws_retire = 1; ws_dest = 0;
        ds_valid = 1; ds_rs = 0; ds_use_rs = 1;
        tick();
        idle_inputs();
        #1 chk("r0_err", 32'(sb_err), 0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            ds_valid     = 1'($urandom);
            ds_use_rs    = 1'($urandom);
            ds_use_rt    = 1'($urandom);
            ds_rs        = 5'($urandom_range(0, 7));
            ds_rt        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            issue        = ($urandom_range(0, 2) == 0);
            issue_we     = ($urandom_range(0, 3) != 0);
            issue_late   = 1'($urandom);
            issue_dest   = 5'($urandom_range(0, 7));
            es_late_done = ($urandom_range(0, 2) == 0);
            es_late_dest = 5'($urandom_range(0, 7));
            ws_retire    = ($urandom_range(0, 2) == 0);
            ws_dest      = 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        reset = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-hazard scoreboard that controls instruction issue from the decode stage. It tracks outstanding GPR writes and which ones are late-result (load) writes still in execute. It asserts a decode-stall request when a source register can't yet be supplied by the execute/memory/writeback bypass network. It sits beside the decode stage, fed by issue, execute-completion and writeback-retire events, and it replaces per-stage destination comparison for load-use stalls.

## Interface
- NUM_GPR, 32, number of architectural registers; r0 is never tracked
- CNT_W, 2, width of per-register outstanding-write counter (max 3 in flight: ES, MS, WS)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard all in-flight tracking (exception/redirect)
- ds_valid  in  1  decode holds a valid instruction
- ds_rs, ds_rt  in  5 each  decode source register numbers
- ds_use_rs, ds_use_rt  in  1 each  instruction actually reads rs / rt
- issue  in  1  decode→execute transfer this cycle (ds_to_es_valid & es_allowin)
- issue_we  in  1  issuing instruction writes a GPR
- issue_dest  in  5  issuing instruction destination
- issue_late  in  1  issuing instruction's result is unavailable in ES (load)
- es_late_done  in  1  late-result instruction leaves ES this cycle
- es_late_dest  in  5  its destination
- ws_retire  in  1  writeback commits a GPR write this cycle
- ws_dest  in  5  committed destination
- sb_stall  out  1  decode must hold (drives ds_ready_go low)
- pending_any  out  1  at least one counter nonzero
- sb_err  out  1  sticky counter overflow/underflow flag

## Operation
- State per register r (1..NUM_GPR-1): cnt[r] (CNT_W bits) and late[r] (1 bit). All zero after reset.
- Issue event: issue & issue_we & issue_dest≠0 → cnt[issue_dest]+1; if also issue_late → late[issue_dest] set.
- Retire event: ws_retire & ws_dest≠0 → cnt[ws_dest]−1.
- Late clear: es_late_done & es_late_dest≠0 → late[es_late_dest] cleared.
- Issue and retire to the same register in the same cycle → cnt unchanged, with no error.
- Late set and clear to the same register in the same cycle → set wins, because the new load is entering ES.
- Overflow: an increment at cnt=2^CNT_W−1 leaves cnt held at max and sets sb_err.
- Underflow: a decrement at cnt=0 leaves cnt held at 0 and sets sb_err.
- sb_err clears only on reset. flush does not clear it.
- Events to r0 are ignored entirely and never raise an error.
- sb_stall = ds_valid & ((ds_use_rs & ds_rs≠0 & late[ds_rs]) | (ds_use_rt & ds_rt≠0 & late[ds_rt])).
  - This is combinational from registered state only. Inputs issue / es_late_done of the current cycle do not affect it.
  - Non-late pending writes never stall; they are served by bypass.
- pending_any = OR of all cnt[r]≠0.
- flush: the next cycle shows all cnt=0 and late=0. Flush overrides issue, retire and late-clear in the same cycle.

## Timing
- All state updates occur at posedge clk and are visible the following cycle.
- Load-use sequence:
  - Cycle N: a load issues.
  - Cycle N+1: the dependent instruction in decode sees sb_stall=1.
  - Cycle N+1: the load leaves ES (es_late_done).
  - Cycle N+2: sb_stall=0 and the consumer issues with the MS-stage bypass. This is a one-cycle bubble.
- Reset values: sb_stall=0 (late all zero), pending_any=0, sb_err=0.
- reset mid-operation discards all counts. The environment also resets the pipeline, so no retire follows.
- An instruction stalled by sb_stall produces no issue pulse. The upstream handshake guarantees this.

## Structure
- Shared package mycpu_sb_pkg holds NUM_GPR, CNT_W and a GPR index type (5 bits). The same constants are used by decode.
- Sub-module sb_entry: one register's cnt/late with inc, dec, set_late, clr_late and flush inputs, plus ovf/unf outputs. It is instantiated NUM_GPR−1 times by a generate loop.
- The top level decodes events to one-hot, ORs the error pulses into sb_err, and muxes late[] for the stall.

## Test plan
- Reset, then idle: sb_stall=0, pending_any=0, sb_err=0 for 10 cycles.
- Load-use:
  - Stimulus: issue lw dest=8 late=1. Next cycle ds_valid, ds_rs=8, ds_use_rs=1, then es_late_done dest=8.
  - Required: sb_stall=1 for exactly 1 cycle, then 0. cnt[8]=1 until ws_retire dest=8, then pending_any=0.
- ALU dependency:
  - Stimulus: issue addu dest=5 late=0, then a consumer reading rs=5.
  - Required: sb_stall never asserts.
- Simultaneous issue and retire of dest=3 while cnt[3]=1: cnt stays 1, and sb_err stays 0.
- Overflow/underflow:
  - Overflow stimulus: 4 issues to dest=9 with no retire. Required: cnt[9]=3 and sb_err=1.
  - Underflow stimulus: after reset, ws_retire dest=4. Required: cnt[4]=0 and sb_err=1.
- Flush with issue in the same cycle, following a load to dest=10 (late[10]=1): the next cycle shows late[10]=0, pending_any=0 and sb_stall=0 for rs=10. Writes to r0 never change pending_any.
